pipeline_hazard_controller: RTL and testbench

//  Sequences the 5-stage pipeline registers (PC, IF/ID, ID/EXE, EXE/MEM).

---
 rtl/pipeline_hazard_controller.sv | 156 +++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - pipeline register sequencing with load-use, branch flush and memory-wait handling
//
// Purpose: drives the PC, IF/ID, ID/EXE and EXE/MEM load enables of a 5-stage pipeline.
//   It inserts one bubble on a load-use hazard and flushes IF/ID and ID/EXE on a taken
//   branch resolved in EXE. It freezes the pipe while the data-memory handshake is
//   pending, and halts when the memory wait exceeds MEM_TIMEOUT cycles.
//   Saturating counters track stall cycles and branch flushes.
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   id_rn_num/id_rm_num/id_uses_rn/rm  source operands of the instruction in ID
//   exe_rd_num/exe_load/exe_reg_write  destination info of the instruction in EXE
//   branch_taken                       taken branch resolved in EXE
//   mem_req/mem_ready                  data-memory handshake of the MEM stage
//   pc_en..exe_mem_en                  pipeline register enables
//   if_id_flush/id_exe_bubble          NOP insertion
//   state/mem_timeout                  FSM state (0 RUN, 1 MEM_WAIT, 2 HALT), halt flag
//   stall_cycles/flush_count           saturating performance counters
module pipeline_hazard_controller #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       id_rn_num,
    input  logic [3:0]       id_rm_num,
    input  logic             id_uses_rn,
    input  logic             id_uses_rm,
    input  logic [3:0]       exe_rd_num,
    input  logic             exe_load,
    input  logic             exe_reg_write,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_exe_en,
    output logic             id_exe_bubble,
    output logic             exe_mem_en,
    output logic [1:0]       state,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_HALT     = 2'd2
    } state_t;

    state_t            state_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              load_use;
    logic              frozen;
    logic              do_decode;

    assign load_use = exe_load & exe_reg_write &
                      ((id_uses_rn & (id_rn_num == exe_rd_num)) |
                       (id_uses_rm & (id_rm_num == exe_rd_num)));

    // do_decode: the hazard/branch rules apply this cycle; frozen: memory holds the pipe.
    // Both are forced low under reset so every enable drops immediately.
    always_comb begin
        frozen    = 1'b0;
        do_decode = 1'b0;
        case (state_q)
            S_RUN: begin
                if (mem_req && !mem_ready) frozen    = 1'b1;
                else                       do_decode = 1'b1;
            end
            S_MEM_WAIT: begin
                if (mem_ready) do_decode = 1'b1;
                else           frozen    = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            frozen    = 1'b0;
            do_decode = 1'b0;
        end
    end

    always_comb begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        if_id_flush   = 1'b0;
        id_exe_en     = 1'b0;
        id_exe_bubble = 1'b0;
        exe_mem_en    = 1'b0;
        if (do_decode) begin
            if (branch_taken) begin
                // Branch outranks load-use: the hazardous ID instruction is flushed anyway.
                pc_en         = 1'b1;
                if_id_en      = 1'b1;
                if_id_flush   = 1'b1;
                id_exe_en     = 1'b1;
                id_exe_bubble = 1'b1;
                exe_mem_en    = 1'b1;
            end else if (load_use) begin
                // Hold PC and IF/ID for one cycle; the load moves on so the hazard clears.
                id_exe_en     = 1'b1;
                id_exe_bubble = 1'b1;
                exe_mem_en    = 1'b1;
            end else begin
                pc_en         = 1'b1;
                if_id_en      = 1'b1;
                id_exe_en     = 1'b1;
                exe_mem_en    = 1'b1;
            end
        end
    end

    assign state       = state_q;
    assign mem_timeout = (state_q == S_HALT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_RUN;
            wait_cnt     <= '0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (frozen) begin
                        state_q  <= S_MEM_WAIT;
                        wait_cnt <= WAIT_ONE;
                    end
                end
                S_MEM_WAIT: begin
                    if (mem_ready) begin
                        state_q  <= S_RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt < WAIT_MAX) begin
                        wait_cnt <= wait_cnt + WAIT_ONE;
                    end else begin
                        state_q  <= S_HALT;
                    end
                end
                default: ;
            endcase

            if (state_q != S_HALT && !pc_en && stall_cycles != CNT_MAX)
                stall_cycles <= stall_cycles + 1'b1;
            if (do_decode && branch_taken && flush_count != CNT_MAX)
                flush_count <= flush_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - self-checking bench for pipeline_hazard_controller
module tb_pipeline_hazard_controller;

    localparam int MT    = 4;
    localparam int CW    = 5;
    localparam int SAT   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    id_rn_num, id_rm_num, exe_rd_num;
    logic          id_uses_rn, id_uses_rm, exe_load, exe_reg_write;
    logic          branch_taken, mem_req, mem_ready;
    logic          pc_en, if_id_en, if_id_flush, id_exe_en, id_exe_bubble, exe_mem_en;
    logic [1:0]    state;
    logic          mem_timeout;
    logic [CW-1:0] stall_cycles, flush_count;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 RUN, 1 waiting on memory, 2 halted.
    int m_state, m_wait, m_stall, m_flush;

    pipeline_hazard_controller #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_rn_num(id_rn_num), .id_rm_num(id_rm_num),
        .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
        .exe_rd_num(exe_rd_num), .exe_load(exe_load), .exe_reg_write(exe_reg_write),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_exe_en(id_exe_en), .id_exe_bubble(id_exe_bubble), .exe_mem_en(exe_mem_en),
        .state(state), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {pc_en, if_id_en, if_id_flush, id_exe_en, id_exe_bubble, exe_mem_en}
    function automatic logic [5:0] exp_ctrl();
        bit lu, fz;
        lu = exe_load && exe_reg_write &&
             ((id_uses_rn && id_rn_num == exe_rd_num) || (id_uses_rm && id_rm_num == exe_rd_num));
        fz = (m_state == 2) || (m_state == 0 && mem_req && !mem_ready) || (m_state == 1 && !mem_ready);
        if (fz)           return 6'b000000;
        if (branch_taken) return 6'b111111;
        if (lu)           return 6'b000111;
        return 6'b110101;
    endfunction

    function automatic void model_update();
        logic [5:0] e;
        e = exp_ctrl();
        if (m_state != 2 && !e[5]) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
        if (e != 6'b0 && branch_taken) m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
        if (m_state == 0) begin
            if (mem_req && !mem_ready) begin m_state = 1; m_wait = 1; end
        end else if (m_state == 1) begin
            if (mem_ready)        begin m_state = 0; m_wait = 0; end
            else if (m_wait < MT) m_wait++;
            else                  m_state = 2;
        end
    endfunction

    function automatic void model_reset();
        m_state = 0; m_wait = 0; m_stall = 0; m_flush = 0;
    endfunction

    task automatic idle_inputs();
        id_rn_num = 0; id_rm_num = 0; exe_rd_num = 0;
        id_uses_rn = 0; id_uses_rm = 0; exe_load = 0; exe_reg_write = 0;
        branch_taken = 0; mem_req = 0; mem_ready = 0;
    endtask

    // Called at posedge+1 with inputs set; checks mid-cycle, advances one clock.
    task automatic step(input string tag);
        #3;
        chk({tag, ".ctrl"}, {pc_en, if_id_en, if_id_flush, id_exe_en, id_exe_bubble, exe_mem_en}, exp_ctrl());
        chk({tag, ".state"}, state, m_state);
        chk({tag, ".timeout"}, mem_timeout, m_state == 2);
        chk({tag, ".stall"}, stall_cycles, m_stall);
        chk({tag, ".flush"}, flush_count, m_flush);
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Inputs idle so an ungated decode would show enables of 1 during reset.
    task automatic do_reset(input string tag);
        idle_inputs();
        reset = 1'b1;
        #1;
        chk({tag, ".rst_ctrl"}, {pc_en, if_id_en, if_id_flush, id_exe_en, id_exe_bubble, exe_mem_en}, 6'b0);
        chk({tag, ".rst_state"}, state, 0);
        chk({tag, ".rst_timeout"}, mem_timeout, 0);
        chk({tag, ".rst_cnt"}, {stall_cycles, flush_count}, 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic set_load_use(input bit reg_write, input bit uses_rn);
        exe_load = 1; exe_reg_write = reg_write; exe_rd_num = 3;
        id_rn_num = 3; id_uses_rn = uses_rn; id_rm_num = 7; id_uses_rm = 0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        model_reset();
        #12;
        do_reset("init");

        // Load-use on Rn -> one bubble, then clear
        set_load_use(1, 1);
        step("lu");
        exe_load = 0;
        step("lu_clear");
        chk("lu.stall_total", stall_cycles, 1);

        // No hazard without operand use or without register write
        do_reset("r2");
        set_load_use(1, 0);
        step("no_use");
        set_load_use(0, 1);
        step("no_write");
        chk("nolu.stall_total", stall_cycles, 0);

        // Load-use on Rm with register 15
        idle_inputs();
        exe_load = 1; exe_reg_write = 1; exe_rd_num = 15; id_rm_num = 15; id_uses_rm = 1;
        step("lu_rm15");

        // Branch wins over load-use
        do_reset("r3");
        set_load_use(1, 1);
        branch_taken = 1;
        step("br_lu");
        idle_inputs();
        step("br_after");
        chk("br.flush_total", flush_count, 1);
        chk("br.stall_total", stall_cycles, 0);

        // Memory wait: 3 frozen cycles then ready with decode as RUN
        do_reset("r4");
        mem_req = 1; mem_ready = 0;
        repeat (3) step("memwait");
        mem_ready = 1;
        step("memready");
        idle_inputs();
        step("memdone");
        chk("mem.stall_total", stall_cycles, 3);

        // Timeout -> HALT after MT+1 frozen cycles, then held
        do_reset("r5");
        mem_req = 1; mem_ready = 0;
        repeat (MT + 1) step("to");
        chk("to.state", state, 2);
        chk("to.stall_total", stall_cycles, MT + 1);
        mem_ready = 1; branch_taken = 1;
        repeat (3) step("halt_hold");
        chk("halt.stall_held", stall_cycles, MT + 1);
        do_reset("r5b");

        // Asynchronous reset mid-cycle in MEM_WAIT with wait count 2
        mem_req = 1; mem_ready = 0;
        step("ar_enter");
        step("ar_wait");
        #2;
        chk("ar.pre_state", state, 1);
        idle_inputs();
        reset = 1'b1;
        #1;
        chk("ar.ctrl", {pc_en, if_id_en, if_id_flush, id_exe_en, id_exe_bubble, exe_mem_en}, 6'b0);
        chk("ar.state", state, 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        mem_req = 1; mem_ready = 0;
        repeat (MT) step("ar_restart");
        chk("ar.still_waiting", state, 1);
        step("ar_last");
        chk("ar.halt", state, 2);
        do_reset("r6");

        // Counter saturation
        set_load_use(1, 1);
        repeat (SAT + 4) step("sat_stall");
        chk("sat.stall", stall_cycles, SAT);
        idle_inputs();
        branch_taken = 1;
        repeat (SAT + 4) step("sat_flush");
        chk("sat.flush", flush_count, SAT);
        do_reset("r7");

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            id_rn_num     = 4'($urandom_range(0, 3));
            id_rm_num     = 4'($urandom_range(0, 3));
            exe_rd_num    = 4'($urandom_range(0, 3));
            id_uses_rn    = 1'($urandom);
            id_uses_rm    = 1'($urandom);
            exe_load      = 1'($urandom);
            exe_reg_write = 1'($urandom);
            branch_taken  = ($urandom_range(0, 5) == 0);
            mem_req       = ($urandom_range(0, 2) == 0);
            mem_ready     = 1'($urandom);
            step("rand");
            if (m_state == 2 && $urandom_range(0, 3) == 0) do_reset("rand_rst");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
